// File: rtl/sm_input_pkg.sv
// Shared constants and helpers for the board input debouncer.
//   DEFAULT_DEBOUNCE_CYCLES : stable cycles needed before a new level is accepted
//   DEFAULT_KEY_W           : number of push-button inputs
//   DEFAULT_SW_W            : number of slide-switch inputs
//   KEY_INVERT / SW_INVERT  : polarity of each input class (buttons are active-low)
//   cnt_width()             : width of a counter that can hold 0..cycles
package sm_input_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
    localparam int DEFAULT_KEY_W           = 4;
    localparam int DEFAULT_SW_W            = 10;

    localparam bit KEY_INVERT = 1'b1;
    localparam bit SW_INVERT  = 1'b0;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/sm_debounce_bit.sv
// One-bit synchronizer + debounce counter + edge pulse generator.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset
//   raw   : asynchronous input bit (polarity set by INVERT)
//   level : debounced level, active-high after optional inversion
//   rise  : one-cycle pulse when level goes 0 -> 1
//   fall  : one-cycle pulse when level goes 1 -> 0
// All outputs are flops; nothing reaches them from raw without the synchronizer.
import sm_input_pkg::*;

module sm_debounce_bit #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit INVERT          = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // Idle value of the raw pin, so reset never looks like an activation.
    localparam logic SYNC_RST = INVERT ? 1'b1 : 1'b0;

    logic             sync1_r;
    logic             sync2_r;
    logic             bit_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             level_r;
    logic             level_nxt_s;
    logic             rise_r;
    logic             rise_nxt_s;
    logic             fall_r;
    logic             fall_nxt_s;

    // Polarity correction happens only after the second synchronizer flop.
    assign bit_s = sync2_r ^ INVERT;

    // Counter / level decision: count while differing, toggle on the last count.
    always_comb begin
        cnt_nxt_s   = '0;
        level_nxt_s = level_r;
        rise_nxt_s  = 1'b0;
        fall_nxt_s  = 1'b0;
        if (bit_s != level_r) begin
            if (cnt_r == CNT_LAST) begin
                level_nxt_s = ~level_r;
                rise_nxt_s  = ~level_r;
                fall_nxt_s  = level_r;
                cnt_nxt_s   = '0;
            end else begin
                cnt_nxt_s = cnt_r + CNT_W'(1);
            end
        end else begin
            // Matching again before acceptance discards any partial count.
            cnt_nxt_s = '0;
        end
    end

    // Synchronizer, counter, level and pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= SYNC_RST;
            sync2_r <= SYNC_RST;
            cnt_r   <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
            cnt_r   <= cnt_nxt_s;
            level_r <= level_nxt_s;
            rise_r  <= rise_nxt_s;
            fall_r  <= fall_nxt_s;
        end
    end

    assign level = level_r;
    assign rise  = rise_r;
    assign fall  = fall_r;

endmodule

// File: rtl/sm_input_debounce.sv
// Debouncer for a bank of board push-buttons and slide switches.
//   clk         : rising-edge clock
//   rst         : synchronous active-high reset
//   key_raw     : asynchronous buttons, active-low (0 = pressed)
//   sw_raw      : asynchronous switches, active-high
//   key_level   : debounced button state, 1 = pressed
//   key_press   : one-cycle pulse per accepted press
//   key_release : one-cycle pulse per accepted release
//   sw_level    : debounced switch state
//   sw_change   : one-cycle pulse on any accepted switch transition
// Each bit is handled by its own independent sm_debounce_bit instance.
import sm_input_pkg::*;

module sm_input_debounce #(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int KEY_W           = DEFAULT_KEY_W,
    parameter int SW_W            = DEFAULT_SW_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [KEY_W-1:0] key_raw,
    input  logic [SW_W-1:0]  sw_raw,
    output logic [KEY_W-1:0] key_level,
    output logic [KEY_W-1:0] key_press,
    output logic [KEY_W-1:0] key_release,
    output logic [SW_W-1:0]  sw_level,
    output logic [SW_W-1:0]  sw_change
);

    logic [SW_W-1:0] sw_rise_s;
    logic [SW_W-1:0] sw_fall_s;

    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_key
        sm_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (KEY_INVERT)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (key_raw[gi]),
            .level (key_level[gi]),
            .rise  (key_press[gi]),
            .fall  (key_release[gi])
        );
    end

    for (genvar gj = 0; gj < SW_W; gj++) begin : g_sw
        sm_debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .INVERT          (SW_INVERT)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .raw   (sw_raw[gj]),
            .level (sw_level[gj]),
            .rise  (sw_rise_s[gj]),
            .fall  (sw_fall_s[gj])
        );
    end

    // Rise and fall are mutually exclusive flops, so their OR is a clean pulse.
    assign sw_change = sw_rise_s | sw_fall_s;

endmodule

// File: tb/tb_sm_input_debounce.sv
// Scoreboard bench for sm_input_debounce with DEBOUNCE_CYCLES = 4.
// The driver records each expected accepted transition (cycle, kind, bit) when
// it changes a raw input; the negedge monitor retires the entries due in the
// current cycle and compares every output against the expected state.
module tb_sm_input_debounce;

    localparam int DC    = 4;
    localparam int KEY_W = 4;
    localparam int SW_W  = 10;
    localparam int LAT   = 2 + DC;

    localparam int EV_PRESS   = 0;
    localparam int EV_RELEASE = 1;
    localparam int EV_CHANGE  = 2;

    typedef struct {
        int cyc;
        int kind;
        int idx;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [KEY_W-1:0] key_raw = '1;
    logic [SW_W-1:0]  sw_raw = '0;
    logic [KEY_W-1:0] key_level;
    logic [KEY_W-1:0] key_press;
    logic [KEY_W-1:0] key_release;
    logic [SW_W-1:0]  sw_level;
    logic [SW_W-1:0]  sw_change;

    ev_t sb_q[$];
    int  cyc = 0;
    bit  rst_at_edge = 1'b0;
    bit  mon_en = 1'b0;
    int  n_checks = 0;
    int  n_fail = 0;

    logic [KEY_W-1:0] exp_key_level = '0;
    logic [SW_W-1:0]  exp_sw_level = '0;
    logic [KEY_W-1:0] exp_press;
    logic [KEY_W-1:0] exp_release;
    logic [SW_W-1:0]  exp_change;

    sm_input_debounce #(
        .DEBOUNCE_CYCLES (DC),
        .KEY_W           (KEY_W),
        .SW_W            (SW_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_raw     (key_raw),
        .sw_raw      (sw_raw),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .sw_level    (sw_level),
        .sw_change   (sw_change)
    );

    always #5 clk = ~clk;

    // Cycle counter and record of whether reset was sampled at this edge.
    always @(posedge clk) begin
        cyc         = cyc + 1;
        rst_at_edge = rst;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Retire due scoreboard entries and compare all outputs once per cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_press   = '0;
            exp_release = '0;
            exp_change  = '0;
            if (rst_at_edge) begin
                exp_key_level = '0;
                exp_sw_level  = '0;
            end
            for (int i = sb_q.size() - 1; i >= 0; i--) begin
                if (sb_q[i].cyc == cyc) begin
                    case (sb_q[i].kind)
                        EV_PRESS: begin
                            exp_press[sb_q[i].idx]     = 1'b1;
                            exp_key_level[sb_q[i].idx] = 1'b1;
                        end
                        EV_RELEASE: begin
                            exp_release[sb_q[i].idx]   = 1'b1;
                            exp_key_level[sb_q[i].idx] = 1'b0;
                        end
                        default: begin
                            exp_change[sb_q[i].idx]   = 1'b1;
                            exp_sw_level[sb_q[i].idx] = ~exp_sw_level[sb_q[i].idx];
                        end
                    endcase
                    sb_q.delete(i);
                end
            end
            check_eq("key_level", 32'(key_level), 32'(exp_key_level));
            check_eq("key_press", 32'(key_press), 32'(exp_press));
            check_eq("key_release", 32'(key_release), 32'(exp_release));
            check_eq("sw_level", 32'(sw_level), 32'(exp_sw_level));
            check_eq("sw_change", 32'(sw_change), 32'(exp_change));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int kind, input int idx);
        ev_t e;
        e.cyc  = cyc + LAT;
        e.kind = kind;
        e.idx  = idx;
        sb_q.push_back(e);
    endtask

    task automatic set_key(input int idx, input bit pressed);
        key_raw[idx] = ~pressed;
        push_ev(pressed ? EV_PRESS : EV_RELEASE, idx);
    endtask

    task automatic set_sw(input int idx, input bit val);
        sw_raw[idx] = val;
        push_ev(EV_CHANGE, idx);
    endtask

    // Reset for n cycles; pending acceptances are lost, held inputs re-accepted.
    task automatic do_reset(input int n);
        ev_t keep_q[$];
        rst = 1'b1;
        foreach (sb_q[i]) begin
            if (sb_q[i].cyc <= cyc) keep_q.push_back(sb_q[i]);
        end
        sb_q = keep_q;
        tick(n);
        rst = 1'b0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key_raw[i] == 1'b0) push_ev(EV_PRESS, i);
        end
        for (int i = 0; i < SW_W; i++) begin
            if (sw_raw[i] == 1'b1) push_ev(EV_CHANGE, i);
        end
    endtask

    initial begin
        tick(1);
        mon_en = 1'b1;
        do_reset(2);
        tick(20);

        // Clean press of key 0.
        set_key(0, 1'b1);
        tick(10);

        // Switch 3 glitch one cycle short of acceptance: discarded.
        sw_raw[3] = 1'b1;
        tick(3);
        sw_raw[3] = 1'b0;
        tick(12);

        // Simultaneous transitions on independent bits.
        set_sw(9, 1'b1);
        set_key(2, 1'b1);
        tick(10);

        // Press then release of key 1.
        set_key(1, 1'b1);
        tick(10);
        set_key(1, 1'b0);
        tick(10);

        // Bouncing switch 0: only the final settled edge is accepted.
        sw_raw[0] = 1'b1;
        tick(1);
        sw_raw[0] = 1'b0;
        tick(1);
        set_sw(0, 1'b1);
        tick(10);

        // Simultaneous release/clear.
        set_sw(9, 1'b0);
        set_key(2, 1'b0);
        tick(10);

        // Reset three cycles into a pending key 3 press, key kept held.
        set_key(3, 1'b1);
        tick(3);
        do_reset(2);
        tick(12);

        // Releases after the reset re-acceptance.
        set_key(3, 1'b0);
        set_key(0, 1'b0);
        set_sw(0, 1'b0);
        tick(12);

        check_eq("sb_queue_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
